// File: rtl/pipe_redirect_ctrl_if.sv
// Redirect/hazard control bundle between EX/ID resolution and the IF/ID registers.
// master drives the EX/ID status, slave (pipe_redirect_ctrl) returns flags and enables.
interface pipe_redirect_ctrl_if #(
    parameter int XLEN = 32
);
    logic            ex_valid;
    logic            ex_is_branch;
    logic            ex_branch_taken;
    logic            ex_is_jump;
    logic            ex_is_mret;
    logic [XLEN-1:0] ex_target;
    logic [XLEN-1:0] csr_mepc;
    logic            ex_is_load;
    logic [4:0]      ex_rd;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic            id_use_rs1;
    logic            id_use_rs2;
    logic            mem_stall;

    logic            ex_is_branch_jump;
    logic            mem_is_branch_jump;
    logic            ex_is_mret_o;
    logic            pc_redirect;
    logic [XLEN-1:0] pc_target;
    logic            pc_write_en;
    logic            ifid_write_en;
    logic            idex_bubble;
    logic [31:0]     perf_redirects;
    logic [31:0]     perf_stall_cycles;

    modport master (
        output ex_valid, ex_is_branch, ex_branch_taken, ex_is_jump, ex_is_mret,
               ex_target, csr_mepc, ex_is_load, ex_rd, id_rs1, id_rs2,
               id_use_rs1, id_use_rs2, mem_stall,
        input  ex_is_branch_jump, mem_is_branch_jump, ex_is_mret_o, pc_redirect,
               pc_target, pc_write_en, ifid_write_en, idex_bubble,
               perf_redirects, perf_stall_cycles
    );

    modport slave (
        input  ex_valid, ex_is_branch, ex_branch_taken, ex_is_jump, ex_is_mret,
               ex_target, csr_mepc, ex_is_load, ex_rd, id_rs1, id_rs2,
               id_use_rs1, id_use_rs2, mem_stall,
        output ex_is_branch_jump, mem_is_branch_jump, ex_is_mret_o, pc_redirect,
               pc_target, pc_write_en, ifid_write_en, idex_bubble,
               perf_redirects, perf_stall_cycles
    );
endinterface

// File: rtl/pipe_redirect_ctrl.sv
// EX-stage redirect resolution, branch/jump shadow FSM and load-use stall control.
// Optional perf counters are built when REDIRECT_PERF_CNT_EN is defined.
module pipe_redirect_ctrl #(
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    pipe_redirect_ctrl_if.slave  bus
);

    typedef enum logic {
        RUN    = 1'b0,
        SHADOW = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            bj;
    logic            mr;
    logic            redirect;
    logic            rs1_hit;
    logic            rs2_hit;
    logic            lu;
    logic [XLEN-1:0] target;

    // EX resolution: branch/jump wins over a coincident mret
    assign bj       = bus.ex_valid & (bus.ex_is_jump | (bus.ex_is_branch & bus.ex_branch_taken));
    assign mr       = bus.ex_valid & bus.ex_is_mret & ~bj;
    assign redirect = bj | mr;
    assign target   = bj ? bus.ex_target : bus.csr_mepc;

    // The ID instruction is squashed on a redirect, so its hazard is moot
    assign rs1_hit = bus.id_use_rs1 & (bus.id_rs1 == bus.ex_rd);
    assign rs2_hit = bus.id_use_rs2 & (bus.id_rs2 == bus.ex_rd);
    assign lu      = bus.ex_valid & bus.ex_is_load & (bus.ex_rd != 5'd0)
                   & (rs1_hit | rs2_hit) & ~redirect;

    assign bus.ex_is_branch_jump = bj;
    assign bus.ex_is_mret_o      = mr;
    assign bus.pc_redirect       = redirect;
    assign bus.pc_target         = target;
    assign bus.pc_write_en       = ~bus.mem_stall & ~lu;
    assign bus.ifid_write_en     = ~bus.mem_stall & ~lu;
    assign bus.idex_bubble       = ~bus.mem_stall & lu;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (!bus.mem_stall && bj) begin
                    state_d = SHADOW;
                end
            end
            SHADOW: begin
                if (!bus.mem_stall) begin
                    state_d = bj ? SHADOW : RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign bus.mem_is_branch_jump = (state_q == SHADOW);

`ifdef REDIRECT_PERF_CNT_EN
    logic [31:0] perf_redirects_q;
    logic [31:0] perf_stall_cycles_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_redirects_q    <= 32'd0;
            perf_stall_cycles_q <= 32'd0;
        end else begin
            if (!bus.mem_stall && redirect) begin
                perf_redirects_q <= perf_redirects_q + 32'd1;
            end
            if (bus.idex_bubble) begin
                perf_stall_cycles_q <= perf_stall_cycles_q + 32'd1;
            end
        end
    end

    assign bus.perf_redirects    = perf_redirects_q;
    assign bus.perf_stall_cycles = perf_stall_cycles_q;
`else
    assign bus.perf_redirects    = 32'd0;
    assign bus.perf_stall_cycles = 32'd0;
`endif

endmodule

// File: doc/pipe_redirect_ctrl.md
# pipe_redirect_ctrl

Control-flow redirect and hazard controller for the 5-stage SCPU datapath. It produces the EX/MEM branch-jump flags and the EX mret flag that the ID-stage instruction mux consumes to squash wrong-path instructions to NOP (`32'h00000013`). It also drives the IF PC redirect and detects load-use hazards, generating pipeline stall and bubble enables. It sits in the datapath control path between the EX-stage resolution logic and the IF/ID pipeline registers.

## Interface
Parameters:
- `XLEN`, 32, PC/target width.

Ports:
- `clk`  in  1  pipeline clock, rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `ex_valid`  in  1  EX stage holds a real instruction.
- `ex_is_branch`  in  1  EX instruction is a conditional branch.
- `ex_branch_taken`  in  1  branch condition true; ignored unless `ex_is_branch`.
- `ex_is_jump`  in  1  EX instruction is JAL/JALR.
- `ex_is_mret`  in  1  EX instruction is MRET.
- `ex_target`  in  XLEN  resolved branch/jump target.
- `csr_mepc`  in  XLEN  current mepc.
- `ex_is_load`  in  1  EX instruction is a load.
- `ex_rd`  in  5  EX destination register.
- `id_rs1`, `id_rs2`  in  5  ID source registers.
- `id_use_rs1`, `id_use_rs2`  in  1  ID instruction reads rs1/rs2.
- `mem_stall`  in  1  memory not ready; the whole pipeline freezes.
- `ex_is_branch_jump`  out  1  EX redirect flag (combinational).
- `mem_is_branch_jump`  out  1  registered shadow of the EX redirect flag.
- `ex_is_mret_o`  out  1  EX mret redirect flag (combinational).
- `pc_redirect`  out  1  IF must load `pc_target`.
- `pc_target`  out  XLEN  redirect address.
- `pc_write_en`  out  1  PC register enable.
- `ifid_write_en`  out  1  IF/ID register enable.
- `idex_bubble`  out  1  load a NOP into ID/EX.
- `perf_redirects`  out  32  redirect event count.
- `perf_stall_cycles`  out  32  load-use stall cycle count.

## Operation
Combinational terms:
- `bj = ex_valid & (ex_is_jump | (ex_is_branch & ex_branch_taken))`.
- `mr = ex_valid & ex_is_mret & ~bj`. Branch/jump has priority over mret; the two occurring together is illegal but resolved this way.
- Outputs: `ex_is_branch_jump = bj`; `ex_is_mret_o = mr`; `pc_redirect = bj | mr`; `pc_target = bj ? ex_target : csr_mepc`.
- Load-use hazard: `lu = ex_valid & ex_is_load & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)) & ~pc_redirect`. A redirect suppresses the hazard because the ID instruction is being squashed.
- Enables:
  - `pc_write_en = ifid_write_en = ~mem_stall & ~lu`.
  - `idex_bubble = ~mem_stall & lu`.

Redirect shadow FSM, two states:
- `RUN` (reset state). On an edge with `~mem_stall & bj`, go to `SHADOW`.
- `SHADOW`:
  - `mem_is_branch_jump = 1`.
  - On an edge with `~mem_stall`, go to `RUN`, or stay in `SHADOW` if `bj` is asserted again.
  - While `mem_stall` is high, remain in `SHADOW`.
- `mem_is_branch_jump` is a registered output, equal to `state == SHADOW`.
- mret does not enter `SHADOW`. mret squashes ID for its EX cycle only.

## Timing
- Reset (asynchronous, `rstn` low): state `RUN`, `mem_is_branch_jump = 0`, perf counters 0. All combinational outputs follow their inputs; with all inputs 0, every output is 0 except `pc_write_en = ifid_write_en = 1`.
- Branch taken in EX at cycle N:
  - `ex_is_branch_jump = 1` in N.
  - `mem_is_branch_jump = 1` in N+1.
  - ID is NOP-squashed in N and N+1, giving 2 squashed slots.
- `mem_stall` held high across a redirect: the EX flag and the FSM both hold; the redirect is taken on the first un-stalled edge.
- Reset asserted in `SHADOW`: the FSM returns to `RUN` immediately and asynchronously.
- Load-use: exactly one bubble cycle. On the next cycle the load has moved to MEM and `lu` drops.

## Configuration
- `REDIRECT_PERF_CNT_EN` defined:
  - `perf_redirects` increments on each edge with `~mem_stall & pc_redirect`.
  - `perf_stall_cycles` increments on each edge with `idex_bubble`.
  - Both counters wrap modulo 2^32 and reset to 0.
- `REDIRECT_PERF_CNT_EN` undefined: both ports are tied to 0 and no counter flops exist.

## Test plan
- Reset check: `rstn` low mid-`SHADOW` -> `mem_is_branch_jump = 0` without waiting for a clock edge; `pc_write_en = 1`; counters 0.
- Taken branch, `ex_target = 0x0000_0100` -> `pc_redirect = 1` and `pc_target = 0x100` in cycle N; `mem_is_branch_jump = 1` in N+1; 0 in N+2.
- MRET with `csr_mepc = 0x0000_0080` -> `ex_is_mret_o = 1`, `pc_target = 0x80`; `mem_is_branch_jump` stays 0.
- Load with `ex_rd = 5`, `id_rs2 = 5`, `id_use_rs2 = 1` -> one cycle of `pc_write_en = 0`, `idex_bubble = 1`. Same case with `ex_rd = 0` -> no stall.
- Taken jump with `mem_stall` high for 3 cycles -> FSM stays in `RUN`, no PC write; `SHADOW` is entered on the first edge after `mem_stall` falls.
- With `REDIRECT_PERF_CNT_EN` defined: 2 redirects and 1 load-use stall -> `perf_redirects = 2`, `perf_stall_cycles = 1`; preload 0xFFFF_FFFF, then one redirect -> counter wraps to 0.
